i2c_wr_queue: RTL and testbench

Register-write command queue and issuer that sits directly upstream of the single-byte I2C write master. Host logic pushes {slave address, register address, data} requests into a small FIFO. The block feeds them one at a time to the master over a start/done handshake. A NACKed transaction is retried a bounded number of times with a fixed back-off; an exhausted retry raises an error pulse and the entry is dropped.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_req_fifo.sv | 71 +++++++
 rtl/i2c_wr_queue.sv | 143 ++++++++++++++
 tb/tb_i2c_wr_queue.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register-write queue: issuer states and the
// queued request record.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    Q_IDLE,
    Q_ISSUE,
    Q_WAIT,
    Q_BACKOFF,
    Q_RETIRE
  } qstate_t;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] slave;
    logic [7:0]            reg_addr;
    logic [7:0]            data;
  } i2c_wr_req_t;

endpackage

// File: rtl/i2c_req_fifo.sv
// Show-ahead circular FIFO with separate occupancy count; the head reads as
// zero while the FIFO is empty.
module i2c_req_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(i2c_wr_req_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != FULL_CNT);
    do_pop   = pop && (count_q != '0);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/i2c_wr_queue.sv
// Register-write command queue: buffers host requests and issues them one at
// a time to the I2C write master, retrying NACKs after a fixed back-off.
module i2c_wr_queue
  import i2c_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MAX_RETRY   = 2,
  parameter int BACKOFF_CYC = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [I2C_ADDR_W-1:0]   req_slave,
  input  logic [7:0]              req_reg,
  input  logic [7:0]              req_data,
  output logic                    m_start,
  output logic [I2C_ADDR_W-1:0]   m_slave,
  output logic [7:0]              m_reg,
  output logic [7:0]              m_data,
  input  logic                    m_busy,
  input  logic                    m_done,
  input  logic                    m_nack,
  output logic                    err_valid,
  output logic [I2C_ADDR_W-1:0]   err_slave,
  output logic [7:0]              err_reg,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [BW-1:0] BOFF_LOAD = BW'(BACKOFF_CYC - 1);

  i2c_wr_req_t req_in, head;
  logic        fifo_full, push, pop;
  logic [LW-1:0] count;

  qstate_t                 state_q, state_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [BW-1:0]           boff_q, boff_d;
  logic                    err_valid_q, err_valid_d;
  logic [I2C_ADDR_W-1:0]   err_slave_q, err_slave_d;
  logic [7:0]              err_reg_q, err_reg_d;

  assign req_in    = '{slave: req_slave, reg_addr: req_reg, data: req_data};
  // Ready follows the registered count, so a pop frees its slot one cycle later.
  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  i2c_req_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(i2c_wr_req_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (req_in),
    .pop  (pop),
    .dout (head),
    .count(count),
    .full (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    boff_d      = boff_q;
    err_valid_d = 1'b0;
    err_slave_d = err_slave_q;
    err_reg_d   = err_reg_q;
    pop         = 1'b0;
    m_start     = 1'b0;
    case (state_q)
      Q_IDLE: begin
        retry_d = '0;
        if (count != '0) state_d = Q_ISSUE;
      end
      Q_ISSUE: begin
        if (!m_busy) begin
          m_start = 1'b1;
          state_d = Q_WAIT;
        end
      end
      Q_WAIT: begin
        if (m_done) begin
          if (!m_nack) begin
            state_d = Q_RETIRE;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            boff_d  = BOFF_LOAD;
            state_d = Q_BACKOFF;
          end else begin
            err_valid_d = 1'b1;
            err_slave_d = head.slave;
            err_reg_d   = head.reg_addr;
            state_d     = Q_RETIRE;
          end
        end
      end
      Q_BACKOFF: begin
        if (boff_q == '0) state_d = Q_ISSUE;
        else              boff_d  = boff_q - BW'(1);
      end
      Q_RETIRE: begin
        pop     = 1'b1;
        retry_d = '0;
        state_d = (count > LW'(1)) ? Q_ISSUE : Q_IDLE;
      end
      default: state_d = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= Q_IDLE;
      retry_q     <= '0;
      boff_q      <= '0;
      err_valid_q <= 1'b0;
      err_slave_q <= '0;
      err_reg_q   <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      boff_q      <= boff_d;
      err_valid_q <= err_valid_d;
      err_slave_q <= err_slave_d;
      err_reg_q   <= err_reg_d;
    end
  end

  assign m_slave   = head.slave;
  assign m_reg     = head.reg_addr;
  assign m_data    = head.data;
  assign err_valid = err_valid_q;
  assign err_slave = err_slave_q;
  assign err_reg   = err_reg_q;
  assign level     = count;
  assign idle      = (count == '0) && (state_q == Q_IDLE);

endmodule

// File: tb/tb_i2c_wr_queue.sv
// Bench for i2c_wr_queue: behavioural write master with slave register memory,
// scoreboard of expected issues/errors popped by an independent monitor.
module tb_i2c_wr_queue;

  localparam int DEPTH       = 4;
  localparam int MAX_RETRY   = 2;
  localparam int BACKOFF_CYC = 32;

  logic       clk, rst;
  logic       req_valid, req_ready;
  logic [6:0] req_slave;
  logic [7:0] req_reg, req_data;
  logic       m_start, m_busy, m_done, m_nack;
  logic [6:0] m_slave;
  logic [7:0] m_reg, m_data;
  logic       err_valid;
  logic [6:0] err_slave;
  logic [7:0] err_reg;
  logic [2:0] level;
  logic       idle;
  logic       mst_done, mst_nack, spur_done, spur_nack;

  assign m_done = mst_done | spur_done;
  assign m_nack = mst_nack | spur_nack;

  i2c_wr_queue #(
    .DEPTH      (DEPTH),
    .MAX_RETRY  (MAX_RETRY),
    .BACKOFF_CYC(BACKOFF_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_slave(req_slave),
    .req_reg  (req_reg),
    .req_data (req_data),
    .m_start  (m_start),
    .m_slave  (m_slave),
    .m_reg    (m_reg),
    .m_data   (m_data),
    .m_busy   (m_busy),
    .m_done   (m_done),
    .m_nack   (m_nack),
    .err_valid(err_valid),
    .err_slave(err_slave),
    .err_reg  (err_reg),
    .level    (level),
    .idle     (idle)
  );

  typedef struct {
    logic [6:0] s;
    logic [7:0] r;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_issue[$];
  exp_t       exp_err[$];
  int         start_log[$];
  int         done_log[$];
  int         err_log[$];
  logic [7:0] smem [256];
  int         nack_budget;
  int         cyc;
  int         total, bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues or reports an error.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_start === 1'b1) begin
        start_log.push_back(cyc);
        if (exp_issue.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: got m_start slave=0x%0h reg=0x%0h required none", m_slave, m_reg);
        end else begin
          e = exp_issue.pop_front();
          check("issue_slave", int'(m_slave), int'(e.s));
          check("issue_reg",   int'(m_reg),   int'(e.r));
          check("issue_data",  int'(m_data),  int'(e.d));
        end
      end
      if (!rst && err_valid === 1'b1) begin
        err_log.push_back(cyc);
        if (exp_err.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_err: got err_valid slave=0x%0h required none", err_slave);
        end else begin
          e = exp_err.pop_front();
          check("err_slave", int'(err_slave), int'(e.s));
          check("err_reg",   int'(err_reg),   int'(e.r));
        end
      end
      if (mst_done) done_log.push_back(cyc);
    end
  end

  // Behavioural master: 1 cycle to go busy, done 3 cycles later; slave 0x33 absent.
  initial begin : mst
    bit nk;
    bit abort;
    mst_done = 1'b0;
    mst_nack = 1'b0;
    m_busy   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && m_start === 1'b1) begin
        if (nack_budget > 0) begin
          nk = 1'b1;
          nack_budget--;
        end else begin
          nk = (m_slave == 7'h33);
        end
        @(posedge clk); #1;
        m_busy = 1'b1;
        abort  = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          if (rst) begin
            abort = 1'b1;
            break;
          end
        end
        m_busy = 1'b0;
        if (!abort) begin
          mst_done = 1'b1;
          mst_nack = nk;
          if (!nk) smem[m_reg] = m_data;
          @(posedge clk); #1;
          mst_done = 1'b0;
          mst_nack = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_req(input logic [6:0] s, input logic [7:0] r, input logic [7:0] d,
                          input int n_iss, input bit err, output int acc);
    exp_t e;
    req_valid = 1'b1;
    req_slave = s;
    req_reg   = r;
    req_data  = d;
    acc       = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got req_ready=0 for 200 cycles required acceptance of reg 0x%0h", r);
    end else begin
      e.s = s;
      e.r = r;
      e.d = d;
      for (int i = 0; i < n_iss; i++) exp_issue.push_back(e);
      if (err) exp_err.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle && level == 3'd0 && !m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got idle=%0b level=%0d after %0d cycles required idle", name, idle, level, budget);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0, d0, e0, acc, acc5;
    bit seen;
    total       = 0;
    bad         = 0;
    nack_budget = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_slave   = '0;
    req_reg     = '0;
    req_data    = '0;
    spur_done   = 1'b0;
    spur_nack   = 1'b0;
    for (int i = 0; i < 256; i++) smem[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_level",     int'(level),     0);
    check("rst_idle",      int'(idle),      1);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_m_start",   int'(m_start),   0);
    check("rst_err_valid", int'(err_valid), 0);
    check("rst_m_fields",  int'({m_slave, m_reg, m_data}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request, ACKed
    s0 = start_log.size();
    push_req(7'h42, 8'h10, 8'hAA, 1, 1'b0, acc);
    wait_idle(100, "t1_idle_timeout");
    check("t1_starts", start_log.size() - s0, 1);
    if (start_log.size() > s0) check("t1_latency", start_log[s0] - acc, 2);
    check("t1_mem", int'(smem[8'h10]), 8'hAA);
    check("t1_level", int'(level), 0);
    check("t1_idle", int'(idle), 1);

    // Five back-to-back requests into a 4-deep queue
    s0 = start_log.size();
    d0 = done_log.size();
    for (int i = 0; i < 4; i++) push_req(7'h42, 8'(i), 8'(8'h50 + i), 1, 1'b0, acc);
    @(negedge clk);
    check("t2_level_full", int'(level), 4);
    check("t2_ready_low", int'(req_ready), 0);
    @(posedge clk); #1;
    push_req(7'h42, 8'h04, 8'h54, 1, 1'b0, acc5);
    wait_idle(400, "t2_idle_timeout");
    check("t2_starts", start_log.size() - s0, 5);
    if (done_log.size() > d0) check("t2_fifth_accept", acc5 - done_log[d0], 2);
    for (int i = 0; i < 5; i++) check("t2_mem", int'(smem[i]), 8'h50 + i);

    // Absent slave: all attempts NACK, entry dropped with error
    s0 = start_log.size();
    d0 = done_log.size();
    e0 = err_log.size();
    push_req(7'h33, 8'h20, 8'h55, 3, 1'b1, acc);
    wait_idle(600, "t3_idle_timeout");
    check("t3_starts", start_log.size() - s0, 3);
    check("t3_errs", err_log.size() - e0, 1);
    if (start_log.size() >= s0 + 3 && done_log.size() >= d0 + 3) begin
      check("t3_gap1", start_log[s0 + 1] - done_log[d0], BACKOFF_CYC + 1);
      check("t3_gap2", start_log[s0 + 2] - done_log[d0 + 1], BACKOFF_CYC + 1);
    end
    if (err_log.size() > e0 && done_log.size() >= d0 + 3)
      check("t3_err_lat", err_log[e0] - done_log[d0 + 2], 1);
    check("t3_mem_untouched", int'(smem[8'h20]), 0);
    check("t3_exp_left", exp_issue.size() + exp_err.size(), 0);

    // First attempt NACK, retry ACKs
    s0 = start_log.size();
    d0 = done_log.size();
    e0 = err_log.size();
    nack_budget = 1;
    push_req(7'h42, 8'h30, 8'h77, 2, 1'b0, acc);
    wait_idle(300, "t4_idle_timeout");
    check("t4_starts", start_log.size() - s0, 2);
    check("t4_errs", err_log.size() - e0, 0);
    check("t4_mem", int'(smem[8'h30]), 8'h77);
    if (start_log.size() >= s0 + 2 && done_log.size() > d0)
      check("t4_gap", start_log[s0 + 1] - done_log[d0], BACKOFF_CYC + 1);

    // Spurious m_done while idle
    s0 = start_log.size();
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_idle_level", int'(level), 0);
    check("t5_idle_idle", int'(idle), 1);
    check("t5_idle_starts", start_log.size() - s0, 0);
    @(posedge clk); #1;

    // Spurious m_done (ACK and NACK flavours) during back-off
    s0 = start_log.size();
    d0 = done_log.size();
    e0 = err_log.size();
    push_req(7'h33, 8'h21, 8'h66, 3, 1'b1, acc);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_log.size() > d0) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_first_done_seen", int'(seen), 1);
    repeat (4) begin @(posedge clk); #1; end
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_nack = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    spur_nack = 1'b0;
    @(negedge clk);
    check("t5_bo_level", int'(level), 1);
    check("t5_bo_idle", int'(idle), 0);
    @(posedge clk); #1;
    wait_idle(600, "t5_idle_timeout");
    check("t5_bo_starts", start_log.size() - s0, 3);
    check("t5_bo_errs", err_log.size() - e0, 1);
    if (start_log.size() >= s0 + 2 && done_log.size() > d0)
      check("t5_bo_gap", start_log[s0 + 1] - done_log[d0], BACKOFF_CYC + 1);
    check("t5_exp_left", exp_issue.size() + exp_err.size(), 0);

    // Reset while waiting on the master with three entries queued
    for (int i = 0; i < 3; i++) push_req(7'h42, 8'(8'h40 + i), 8'(8'h90 + i), 1, 1'b0, acc);
    @(negedge clk);
    check("t6_level_pre", int'(level), 3);
    check("t6_busy_pre", int'(m_busy), 1);
    rst = 1'b1;
    exp_issue.delete();
    exp_err.delete();
    e0 = err_log.size();
    @(negedge clk);
    check("t6_level", int'(level), 0);
    check("t6_idle", int'(idle), 1);
    check("t6_m_start", int'(m_start), 0);
    check("t6_err_valid", int'(err_valid), 0);
    rst = 1'b0;
    s0 = start_log.size();
    repeat (12) @(negedge clk);
    check("t6_no_err", err_log.size() - e0, 0);
    check("t6_no_start", start_log.size() - s0, 0);
    check("t6_mem_untouched", int'(smem[8'h40]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
